// File: rtl/sample_sequencer_pkg.sv
// Shared definitions for the sample sequencer: state encoding and width helpers.
package sample_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Number of bits needed to index `value` items (0 for a single item).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned v = value - 1; v > 0 && value > 1; v = v >> 1) begin
      width++;
    end
    return width;
  endfunction

  // Index width with a floor of one bit so single-entry dimensions still have a port.
  function automatic int unsigned min1_width(input int unsigned count);
    return (clogb2(count) < 1) ? 1 : clogb2(count);
  endfunction

endpackage

// File: rtl/sync_edge_detector.sv
// Two-flop synchroniser followed by a rising-edge detector; emits a one-cycle pulse.
module sync_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign out = sync2_q & ~prev_q;

endmodule

// File: rtl/sample_sequencer.sv
// Turns DAC sample requests into frame/channel-interleaved reads of an external sample memory.
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int unsigned SIZE     = 12,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned AW       = min1_width(DEPTH),
  parameter int unsigned CW       = min1_width(CHANNELS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            next,
  input  logic            start,
  input  logic            stop,
  input  logic            oneshot,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  output logic [CW-1:0]   mem_chan,
  input  logic [SIZE-1:0] mem_data,
  output logic [SIZE-1:0] data,
  output logic [CW-1:0]   channel,
  output logic            valid,
  output logic            busy,
  output logic            done
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LastChan = CW'(CHANNELS - 1);

  logic tick;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic            mode_q, mode_d;
  logic            rd_q, rd_d;
  logic [CW-1:0]   rd_chan_q, rd_chan_d;
  logic [SIZE-1:0] data_q, data_d;
  logic [CW-1:0]   channel_q, channel_d;
  logic            valid_q, valid_d;

  sync_edge_detector u_next_edge (
    .clk (clk),
    .rst (rst),
    .in  (next),
    .out (tick)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    chan_d    = chan_q;
    mode_d    = mode_q;
    rd_d      = 1'b0;
    rd_chan_d = chan_q;
    valid_d   = rd_q;
    data_d    = rd_q ? mem_data : data_q;
    channel_d = rd_q ? rd_chan_q : channel_q;

    // stop outranks start, and both swallow a coincident tick
    if (stop) begin
      if (state_q == StRun) begin
        state_d = StIdle;
      end
    end else if (start) begin
      state_d = StRun;
      addr_d  = '0;
      chan_d  = '0;
      mode_d  = oneshot;
    end else if (state_q == StRun && tick) begin
      rd_d = 1'b1;
      if (chan_q == LastChan) begin
        chan_d = '0;
        if (addr_q == LastAddr) begin
          addr_d = '0;
          if (mode_q) begin
            state_d = StDone;
          end
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end else begin
        chan_d = chan_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      chan_q    <= '0;
      mode_q    <= 1'b0;
      rd_q      <= 1'b0;
      rd_chan_q <= '0;
      data_q    <= '0;
      channel_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      chan_q    <= chan_d;
      mode_q    <= mode_d;
      rd_q      <= rd_d;
      rd_chan_q <= rd_chan_d;
      data_q    <= data_d;
      channel_q <= channel_d;
      valid_q   <= valid_d;
    end
  end

  assign mem_rd   = rd_d;
  assign mem_addr = addr_q;
  assign mem_chan = chan_q;
  assign data     = data_q;
  assign channel  = channel_q;
  assign valid    = valid_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: a 3x2 instance and a 1x1 corner instance share all stimulus.
module tb_sample_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic next = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic oneshot = 1'b0;

  logic        mem_rd_a, valid_a, busy_a, done_a;
  logic [1:0]  mem_addr_a;
  logic [0:0]  mem_chan_a, channel_a;
  logic [11:0] mem_data_a = '0;
  logic [11:0] data_a;

  logic        mem_rd_b, valid_b, busy_b, done_b;
  logic [0:0]  mem_addr_b, mem_chan_b, channel_b;
  logic [11:0] mem_data_b = '0;
  logic [11:0] data_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sample_sequencer #(.SIZE(12), .DEPTH(3), .CHANNELS(2)) u_dut_a (
    .clk(clk), .rst(rst), .next(next), .start(start), .stop(stop), .oneshot(oneshot),
    .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_chan(mem_chan_a), .mem_data(mem_data_a),
    .data(data_a), .channel(channel_a), .valid(valid_a), .busy(busy_a), .done(done_a)
  );

  sample_sequencer #(.SIZE(12), .DEPTH(1), .CHANNELS(1)) u_dut_b (
    .clk(clk), .rst(rst), .next(next), .start(start), .stop(stop), .oneshot(oneshot),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_chan(mem_chan_b), .mem_data(mem_data_b),
    .data(data_b), .channel(channel_b), .valid(valid_b), .busy(busy_b), .done(done_b)
  );

  // Memory word encodes where it came from so each delivered sample is traceable.
  function automatic logic [11:0] pattern(input int a, input int c);
    return 12'(32'h500 + a * 16 + c);
  endfunction

  always @(posedge clk) begin
    if (mem_rd_a) mem_data_a <= pattern(int'(mem_addr_a), int'(mem_chan_a));
    if (mem_rd_b) mem_data_b <= pattern(int'(mem_addr_b), int'(mem_chan_b));
  end

  // ---------------- behavioural model ----------------
  // st: 0 idle, 1 run, 2 done; n counts reads issued since start (read n hits frame n/C, chan n%C)
  int depth[2] = '{3, 1};
  int chans[2] = '{2, 1};
  int st[2], n[2], pend_a[2], pend_c[2], ed[2], ec[2];
  bit mode[2], pend[2], ev[2];
  bit s0, s1, s2;
  int cyc = 0;

  function automatic bit exp_rd(input int i);
    return (s1 && !s2) && st[i] == 1 && !stop && !start;
  endfunction
  function automatic int exp_addr(input int i);
    return (n[i] / chans[i]) % depth[i];
  endfunction
  function automatic int exp_chan(input int i);
    return n[i] % chans[i];
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      s0 = 0; s1 = 0; s2 = 0;
      for (int i = 0; i < 2; i++) begin
        st[i] = 0; n[i] = 0; mode[i] = 0; pend[i] = 0; ev[i] = 0; ed[i] = 0; ec[i] = 0;
        pend_a[i] = 0; pend_c[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bit rd;
        rd = exp_rd(i);
        ev[i] = pend[i];
        if (pend[i]) begin
          ed[i] = int'(pattern(pend_a[i], pend_c[i]));
          ec[i] = pend_c[i];
        end
        pend[i] = rd;
        pend_a[i] = exp_addr(i);
        pend_c[i] = exp_chan(i);
        if (rd) begin
          n[i]++;
          if (n[i] == depth[i] * chans[i]) begin
            n[i] = 0;
            if (mode[i]) st[i] = 2;
          end
        end
        if (stop) begin
          if (st[i] == 1) st[i] = 0;
        end else if (start) begin
          st[i] = 1; n[i] = 0; mode[i] = oneshot;
        end
      end
      s2 = s1; s1 = s0; s0 = next;
    end
  end

  // ---------------- compare ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  int rd_log_a[$], rd_log_b[$], rd_cyc_a[$], vdat_a[$], vchan_a[$], vcyc_a[$], vdat_b[$];

  initial forever begin
    @(negedge clk);
    chk("a_mem_rd", 32'(mem_rd_a), 32'(exp_rd(0)));
    chk("a_mem_addr", 32'(mem_addr_a), exp_addr(0));
    chk("a_mem_chan", 32'(mem_chan_a), exp_chan(0));
    chk("a_valid", 32'(valid_a), 32'(ev[0]));
    chk("a_data", 32'(data_a), ed[0]);
    chk("a_channel", 32'(channel_a), ec[0]);
    chk("a_busy", 32'(busy_a), 32'(st[0] == 1));
    chk("a_done", 32'(done_a), 32'(st[0] == 2));
    chk("b_mem_rd", 32'(mem_rd_b), 32'(exp_rd(1)));
    chk("b_mem_addr", 32'(mem_addr_b), exp_addr(1));
    chk("b_mem_chan", 32'(mem_chan_b), exp_chan(1));
    chk("b_valid", 32'(valid_b), 32'(ev[1]));
    chk("b_data", 32'(data_b), ed[1]);
    chk("b_busy", 32'(busy_b), 32'(st[1] == 1));
    chk("b_done", 32'(done_b), 32'(st[1] == 2));
    if (mem_rd_a === 1'b1) begin
      rd_log_a.push_back(int'(mem_addr_a) * 16 + int'(mem_chan_a));
      rd_cyc_a.push_back(cyc);
    end
    if (valid_a === 1'b1) begin
      vdat_a.push_back(int'(data_a));
      vchan_a.push_back(int'(channel_a));
      vcyc_a.push_back(cyc);
    end
    if (mem_rd_b === 1'b1) rd_log_b.push_back(int'(mem_addr_b) * 16 + int'(mem_chan_b));
    if (valid_b === 1'b1) vdat_b.push_back(int'(data_b));
  end

  // ---------------- stimulus ----------------
  task automatic tick_clk();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    repeat (2) tick_clk();
    next = 1'b0;
    repeat (3) tick_clk();
  endtask

  task automatic pulse_start(input logic os);
    oneshot = os;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    oneshot = ~os;
    tick_clk();
  endtask

  task automatic clear_logs();
    rd_log_a.delete(); rd_log_b.delete(); rd_cyc_a.delete();
    vdat_a.delete(); vchan_a.delete(); vcyc_a.delete(); vdat_b.delete();
  endtask

  // Drive a next edge so its tick lands in the same cycle as a start or stop pulse.
  task automatic tick_with(input bit use_stop);
    next = 1'b1;
    repeat (2) tick_clk();
    if (use_stop) stop = 1'b1;
    else start = 1'b1;
    tick_clk();
    stop = 1'b0;
    start = 1'b0;
    next = 1'b0;
    repeat (3) tick_clk();
  endtask

  int exp_seq[7] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h00};
  int exp_dat[7] = '{12'h500, 12'h501, 12'h510, 12'h511, 12'h520, 12'h521, 12'h500};
  int e0;

  initial begin
    repeat (3) tick_clk();
    chk("reset_busy", 32'(busy_a), 0);
    chk("reset_data", 32'(data_a), 0);
    chk("reset_addr", 32'(mem_addr_a), 0);
    rst = 1'b0;
    tick_clk();

    // Looped playback: six reads cover the whole waveform, the seventh wraps.
    pulse_start(1'b0);
    chk("loop_busy", 32'(busy_a), 1);
    clear_logs();
    repeat (7) pulse_next();
    chk("loop_rd_count", rd_log_a.size(), 7);
    chk("loop_valid_count", vdat_a.size(), 7);
    for (int i = 0; i < 7 && i < rd_log_a.size() && i < vdat_a.size(); i++) begin
      chk($sformatf("loop_addr_chan_%0d", i), rd_log_a[i], exp_seq[i]);
      chk($sformatf("loop_data_%0d", i), vdat_a[i], exp_dat[i]);
      chk($sformatf("loop_channel_%0d", i), vchan_a[i], i % 2);
    end
    chk("corner_loop_rd_count", rd_log_b.size(), 7);
    chk("corner_loop_valid_count", vdat_b.size(), 7);
    for (int i = 0; i < rd_log_b.size(); i++) chk("corner_addr_chan", rd_log_b[i], 0);

    // One-shot playback.
    stop = 1'b1; tick_clk(); stop = 1'b0; tick_clk();
    chk("stop_busy", 32'(busy_a), 0);
    pulse_start(1'b1);
    clear_logs();
    pulse_next();
    chk("corner_oneshot_done", 32'(done_b), 1);
    chk("corner_oneshot_busy", 32'(busy_b), 0);
    repeat (5) pulse_next();
    chk("oneshot_done", 32'(done_a), 1);
    chk("oneshot_busy", 32'(busy_a), 0);
    chk("oneshot_valid_count", vdat_a.size(), 6);
    if (vdat_a.size() == 6) chk("oneshot_last_data", vdat_a[5], 12'h521);
    pulse_next();
    chk("oneshot_no_7th_read", rd_log_a.size(), 6);
    chk("corner_oneshot_reads", rd_log_b.size(), 1);

    // Latency, and a long-held request yields a single read.
    pulse_start(1'b0);
    clear_logs();
    next = 1'b1;
    e0 = cyc + 1;
    repeat (20) tick_clk();
    next = 1'b0;
    repeat (4) tick_clk();
    chk("held_next_one_read", rd_log_a.size(), 1);
    chk("held_next_one_valid", vcyc_a.size(), 1);
    if (rd_cyc_a.size() > 0) chk("latency_mem_rd", rd_cyc_a[0], e0 + 1);
    if (vcyc_a.size() > 0) chk("latency_valid", vcyc_a[0], e0 + 3);

    // stop+tick drops the read; idle ticks do nothing; start+tick zeroes counters.
    clear_logs();
    tick_with(1'b1);
    chk("stop_tick_no_read", rd_log_a.size(), 0);
    chk("stop_tick_busy", 32'(busy_a), 0);
    chk("stop_tick_chan_kept", 32'(mem_chan_a), 1);
    repeat (2) pulse_next();
    chk("idle_no_read", rd_log_a.size(), 0);
    chk("idle_chan_kept", 32'(mem_chan_a), 1);
    tick_with(1'b0);
    chk("start_tick_no_read", rd_log_a.size(), 0);
    chk("start_tick_chan", 32'(mem_chan_a), 0);
    chk("start_tick_busy", 32'(busy_a), 1);

    // Reset the cycle after a read: the read must not complete.
    next = 1'b1;
    repeat (3) tick_clk();
    rst = 1'b1;
    next = 1'b0;
    tick_clk();
    chk("rst_read_issued", rd_log_a.size(), 1);
    chk("rst_outputs", {busy_a, done_a, valid_a, mem_rd_a, data_a != 0}, 0);
    rst = 1'b0;
    repeat (3) tick_clk();
    chk("rst_no_valid", vdat_a.size(), 0);
    chk("rst_idle", 32'(busy_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sample_sequencer.md
# sample_sequencer

Multi-channel sample read sequencer for the signal generator output path. It turns an asynchronous `next` strobe from the DAC side into timed reads of an external sample memory, interleaving `CHANNELS` channels per frame and stepping through `DEPTH` frames. It supports looped or one-shot playback with explicit start/stop control. It sits between the sample memory and the DAC serialiser, and everything runs on `clk` (no derived clocks).

## Interface
- `SIZE`, 12, sample width in bits
- `DEPTH`, 3, frames per waveform (≥1)
- `CHANNELS`, 2, interleaved channels per frame (≥1)
- `AW`, derived: clogb2(DEPTH), minimum 1; `CW`, derived: clogb2(CHANNELS), minimum 1

Reset `rst` is asynchronous and active-high; the clock is `clk`.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `next`  in  1  asynchronous sample-request level from the DAC; rising edge = request
- `start`  in  1  one-cycle pulse: begin playback at frame 0, channel 0
- `stop`  in  1  one-cycle pulse: abort playback, go IDLE
- `oneshot`  in  1  1 = stop after last frame, 0 = loop; sampled at `start`
- `mem_rd`  out  1  memory read strobe
- `mem_addr`  out  AW  frame address for the read
- `mem_chan`  out  CW  channel index for the read
- `mem_data`  in  SIZE  memory read data, valid the cycle after `mem_rd`
- `data`  out  SIZE  last sample delivered (held)
- `channel`  out  CW  channel of `data` (held)
- `valid`  out  1  one-cycle pulse: `data`/`channel` updated
- `busy`  out  1  state == RUN
- `done`  out  1  level, state == DONE

## Operation
- States: IDLE (reset), RUN, DONE.
  - IDLE/DONE + `start` → RUN, with addr=0, chan=0, and the mode latched from `oneshot`.
  - RUN + `stop` → IDLE.
  - RUN + the last read of the last frame in one-shot mode → DONE.
  - DONE persists until `start`.
- `next` passes through a 2-FF synchroniser plus a previous-value FF. `tick` = sync2 & ~prev, a one-cycle pulse per rising edge.
- In RUN, `tick` drives `mem_rd`=1 combinationally, with `mem_addr`/`mem_chan` equal to the current counters. Ticks in IDLE/DONE are dropped.
- Counter advance on each issued read:
  - chan+1.
  - If chan==CHANNELS-1: chan←0 and addr+1.
  - If additionally addr==DEPTH-1: addr←0 (loop mode) or go to DONE (one-shot).
- Read pipeline: in the cycle after `mem_rd`, the block registers `mem_data` into `data` and the issued channel into `channel`, and pulses `valid`.
  - A read issued in the same cycle that RUN→DONE or RUN→IDLE still completes (`valid` fires).
- Simultaneous events:
  - `stop`+`start`: stop wins.
  - `start`+`tick`: start wins; the tick is dropped and the counters are zeroed.
  - `stop`+`tick`: the tick is dropped and there is no `mem_rd`.
- `oneshot` changes during RUN are ignored.

## Timing
- Reset values: `data`=0, `channel`=0, `valid`=0, `mem_rd`=0, `mem_addr`=0, `mem_chan`=0, `busy`=0, `done`=0; state IDLE; sync FFs 0.
- `rst` mid-playback aborts immediately. Any read in flight is discarded (no `valid`).
- Latency: if `next` is first sampled high at edge k:
  - `mem_rd` is high between edges k+1 and k+2.
  - The counters advance at k+2.
  - `valid`=1 between k+3 and k+4.
- Throughput: one read per `next` rising edge. `next` must be low for at least 2 clk cycles between requests, so tick spacing is ≥2 cycles and reads overlap safely.
- `busy`/`done` are registered: they change on the edge after `start`/`stop`/the final read.

## Structure
- Shared header: existing `clogb2` function plus state encoding localparams (IDLE=0, RUN=1, DONE=2) and the min-1 width rule for AW/CW.
- Sub-module `sync_edge_detector` (`clk`, `rst`, `in`, `out` pulse). It is synchroniser plus rising-edge detect and is reusable elsewhere.
- The sample memory stays external. The block contains only the FSM, the counters and the output registers.

## Test plan
- Reset, then `start` (loop, DEPTH=3, CHANNELS=2, memory word = {addr,chan} pattern), then 6 `next` pulses. Required: `mem_addr`/`mem_chan` = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1); then a 7th pulse reads (0,0); `valid` fires on each read with matching `channel`.
- One-shot, same config, 6 pulses. Required: `done`=1 and `busy`=0 after the 6th read; the 6th `valid` is still delivered; a 7th pulse gives no `mem_rd`.
- `next` first sampled high at edge 10. Required: `mem_rd` high in cycle 11, `valid` high in cycle 13; `next` held high 20 cycles yields exactly one read.
- `next` pulses while IDLE, and `stop`+`tick` in the same cycle. Required: no `mem_rd` and counters unchanged; `start`+`tick` in the same cycle gives counters 0 and no read.
- `rst` asserted the cycle after `mem_rd`. Required: no `valid`, all outputs 0, state IDLE.
- Corner parameters DEPTH=1, CHANNELS=1. Required: every tick reads (0,0); one-shot goes to DONE after the first read.
